// File: rtl/jtdsp16_rom_arb.sv
// jtdsp16_rom_arb: shares the single program-ROM port of the DSP16 core
// between instruction fetch and table (*pt++) reads. It halts the core while
// an access is outstanding and parks the port during a firmware download.
module jtdsp16_rom_arb #(
  parameter int AW   = 16,
  parameter int TOUT = 255   // wait-clock limit per access, 8-bit counter range
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cen,
  input  logic [AW-1:0] fetch_addr,
  input  logic [AW-1:0] tbl_addr,
  input  logic          pt_read,
  input  logic          dl_en,
  output logic          ext_cs,
  output logic [AW-1:0] ext_addr,
  input  logic          ext_ok,
  input  logic [15:0]   ext_data,
  output logic [15:0]   ins_dout,
  output logic [15:0]   tbl_dout,
  output logic          tbl_valid,
  output logic          halt,
  output logic          busy,
  output logic          err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    TABLE = 2'd2,
    HOLD  = 2'd3
  } state_t;

  localparam logic [7:0] TLIM = 8'(TOUT);

  state_t          state, state_nxt;
  logic            tbl_pend;
  logic [AW-1:0]   tbl_latch;
  logic [7:0]      wcnt;
  logic [7:0]      wcnt_inc;
  logic            ack;
  logic            waiting;
  logic            issue;
  logic            hold_take;

  // ext_ok only counts while a request is actually on the port
  assign ack       = ext_cs && ext_ok;
  // an access clock spent without data from the ROM
  assign waiting   = ((state == FETCH) || (state == TABLE)) && !ext_ok;
  // IDLE launches a new access unless the host owns the ROM
  assign issue     = (state == IDLE) && !dl_en;
  // the core consumes ins_dout on the first cen clock of HOLD
  assign hold_take = (state == HOLD) && cen;
  assign wcnt_inc  = wcnt + 8'd1;

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // next-state: a pending table read always goes before the next fetch
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!dl_en) state_nxt = tbl_pend ? TABLE : FETCH;
      FETCH:   if (ack)    state_nxt = HOLD;
      TABLE:   if (ack)    state_nxt = IDLE;
      HOLD:    if (cen)    state_nxt = IDLE;
      default:             state_nxt = IDLE;
    endcase
  end

  // outputs decoded from state: the core only runs in HOLD
  always_comb begin
    halt = 1'b1;
    busy = 1'b0;
    case (state)
      HOLD:    halt = 1'b0;
      IDLE:    busy = dl_en;
      default: ;
    endcase
  end

  // ROM request strobe and address, held steady until the ROM answers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ext_cs   <= 1'b0;
      ext_addr <= '0;
    end else if (issue) begin
      ext_cs   <= 1'b1;
      ext_addr <= tbl_pend ? tbl_latch : fetch_addr;
    end else if (ack) begin
      ext_cs   <= 1'b0;
    end
  end

  // instruction word capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                        ins_dout <= '0;
    else if (ack && state == FETCH) ins_dout <= ext_data;
  end

  // table word capture with a single-clock valid pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tbl_dout  <= '0;
      tbl_valid <= 1'b0;
    end else begin
      tbl_valid <= ack && (state == TABLE);
      if (ack && state == TABLE) tbl_dout <= ext_data;
    end
  end

  // table request latched at the HOLD handshake, retired when its data lands
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tbl_pend  <= 1'b0;
      tbl_latch <= '0;
    end else if (hold_take && pt_read) begin
      tbl_pend  <= 1'b1;
      tbl_latch <= tbl_addr;
    end else if (ack && state == TABLE) begin
      tbl_pend  <= 1'b0;
    end
  end

  // per-access wait counter; a slow ROM is flagged but never aborted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wcnt <= '0;
      err  <= 1'b0;
    end else begin
      if (state_nxt != state) begin
        wcnt <= '0;
      end else if (waiting && wcnt != TLIM) begin
        wcnt <= wcnt_inc;
        if (wcnt_inc == TLIM) err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_jtdsp16_rom_arb.sv
// Bench for jtdsp16_rom_arb: a random-latency ROM responder, a core model that
// consumes instructions and issues table reads, and a negedge monitor that
// checks everything the DUT presents against queues of expected results.
module tb_jtdsp16_rom_arb;
  localparam int AW   = 16;
  localparam int TOUT = 255;

  logic          clk, rst, cen, pt_read, dl_en, ext_ok;
  logic [AW-1:0] fetch_addr, tbl_addr, ext_addr;
  logic [15:0]   ext_data, ins_dout, tbl_dout;
  logic          ext_cs, tbl_valid, halt, busy, err;

  jtdsp16_rom_arb #(.AW(AW), .TOUT(TOUT)) dut (
    .clk(clk), .rst(rst), .cen(cen), .fetch_addr(fetch_addr), .tbl_addr(tbl_addr),
    .pt_read(pt_read), .dl_en(dl_en), .ext_cs(ext_cs), .ext_addr(ext_addr),
    .ext_ok(ext_ok), .ext_data(ext_data), .ins_dout(ins_dout), .tbl_dout(tbl_dout),
    .tbl_valid(tbl_valid), .halt(halt), .busy(busy), .err(err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int errors = 0;
  int checks = 0;

  logic [15:0] rom [0:65535];
  logic [15:0] addr_q [$];   // expected ROM addresses, in issue order
  logic [15:0] ins_q  [$];   // expected instruction words at each consumption
  logic [15:0] tbl_q  [$];   // expected table words at each tbl_valid

  // stimulus controls
  int          cen_mode = 0;   // 0: every clk, 1: every 4th clk, 2: random
  int          cyc = 0;
  bit          force_pt = 0;
  logic [15:0] force_taddr, force_npc;
  bit          adv_pend = 0;
  logic [15:0] next_pc;
  int          n_consumed = 0;
  // responder controls
  int          lat_fix = -1;
  int          lat_once = -1;
  int          cur_lat = 0;
  // monitor state
  bit          mon_off = 1;
  bit          exp_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // one clock of the core model: drive just after the edge, predict consumption
  task automatic step();
    @(posedge clk); #1;
    if (adv_pend) begin
      fetch_addr = next_pc;
      adv_pend   = 0;
    end
    case (cen_mode)
      0:       cen = 1'b1;
      1:       cen = (cyc % 4 == 0);
      default: cen = ($urandom_range(0, 2) == 0);
    endcase
    cyc++;
    pt_read  = force_pt ? 1'b1 : ($urandom_range(0, 2) == 0);
    tbl_addr = force_pt ? force_taddr : 16'($urandom);
    if (!halt && cen) begin
      n_consumed++;
      if (pt_read) begin
        addr_q.push_back(tbl_addr);
        tbl_q.push_back(rom[tbl_addr]);
      end
      if (force_pt) next_pc = force_npc;
      else if ($urandom_range(0, 3) == 0) next_pc = 16'($urandom);
      else next_pc = fetch_addr + 16'd1;
      adv_pend = 1;
      force_pt = 0;
      addr_q.push_back(next_pc);
      ins_q.push_back(rom[next_pc]);
    end
  endtask

  // ROM side: data after cur_lat wait clocks, spurious ext_ok when idle
  initial begin : responder
    bit act;
    int cnt;
    act = 0; cnt = 0;
    ext_ok = 1'b0; ext_data = '0;
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        ext_ok = 1'b0;
        act    = 0;
      end else if (ext_cs) begin
        if (!act) begin
          act = 1; cnt = 0;
          if (lat_once >= 0) begin cur_lat = lat_once; lat_once = -1; end
          else if (lat_fix >= 0) cur_lat = lat_fix;
          else cur_lat = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 7)) : 0;
        end
        if (cnt >= cur_lat) begin
          ext_ok = 1'b1; ext_data = rom[ext_addr]; act = 0;
        end else begin
          ext_ok = 1'b0; ext_data = 16'($urandom); cnt++;
        end
      end else begin
        ext_ok   = ($urandom_range(0, 7) == 0);
        ext_data = 16'($urandom);
      end
    end
  end

  // monitor: pops the scoreboard whenever the DUT presents something
  initial begin : monitor
    bit          in_acc, prev_halt, prev_cen, prev_tv;
    logic [15:0] acc_addr;
    int          cs_len, waits;
    in_acc = 0; prev_halt = 1; prev_cen = 0; prev_tv = 0;
    acc_addr = '0; cs_len = 0; waits = 0;
    forever begin
      @(negedge clk);
      if (!mon_off) begin
        // HOLD lasts exactly until the first cen clock
        if (!prev_halt && prev_cen)  chk("hold_exit", 32'(halt), 1);
        if (!prev_halt && !prev_cen) chk("hold_stay", 32'(halt), 0);
        if (!halt && cen) begin
          if (ins_q.size() == 0) chk("ins_q_empty", 1, 0);
          else chk("ins_dout", 32'(ins_dout), 32'(ins_q.pop_front()));
        end
        // ROM access tracking
        if (ext_cs) begin
          chk("halt_in_acc", 32'(halt), 1);
          if (!in_acc) begin
            in_acc = 1; acc_addr = ext_addr; cs_len = 0; waits = 0;
            if (addr_q.size() == 0) chk("addr_q_empty", 32'(ext_addr), 32'hFFFF_FFFF);
            else chk("acc_addr", 32'(ext_addr), 32'(addr_q.pop_front()));
          end else begin
            chk("addr_stable", 32'(ext_addr), 32'(acc_addr));
          end
          cs_len++;
          if (waits >= TOUT) exp_err = 1;
          if (waits == TOUT - 1 || waits == TOUT) chk("err_tout", 32'(err), 32'(exp_err));
          if (ext_ok) begin
            in_acc = 0;
            chk("cs_len", cs_len, cur_lat + 1);
            chk("err_acc", 32'(err), 32'(exp_err));
          end else begin
            waits++;
          end
        end else if (in_acc) begin
          chk("cs_drop", 32'(ext_cs), 1);
          in_acc = 0;
        end
        if (tbl_valid) begin
          chk("tbl_pulse", 32'(prev_tv), 0);
          chk("tbl_halt", 32'(halt), 1);
          if (tbl_q.size() == 0) chk("tbl_q_empty", 1, 0);
          else chk("tbl_dout", 32'(tbl_dout), 32'(tbl_q.pop_front()));
        end
        if (busy) begin
          chk("busy_cs", 32'(ext_cs), 0);
          chk("busy_halt", 32'(halt), 1);
          chk("busy_dl", 32'(dl_en), 1);
        end
      end
      prev_halt = halt; prev_cen = cen; prev_tv = tbl_valid;
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin : main
    int n;
    for (int i = 0; i < 65536; i++) rom[i] = 16'($urandom);
    rom[0]      = 16'h1234;
    rom[16'h400] = 16'hBEEF;
    rst = 1'b1; cen = 1'b1; pt_read = 1'b0; dl_en = 1'b0;
    fetch_addr = 16'h0000; tbl_addr = 16'h0000;
    addr_q.push_back(16'h0000);
    ins_q.push_back(rom[0]);
    force_pt = 1; force_taddr = 16'h0400; force_npc = 16'h0001;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_ext_cs",    32'(ext_cs), 0);
    chk("rst_ext_addr",  32'(ext_addr), 0);
    chk("rst_ins_dout",  32'(ins_dout), 0);
    chk("rst_tbl_dout",  32'(tbl_dout), 0);
    chk("rst_tbl_valid", 32'(tbl_valid), 0);
    chk("rst_err",       32'(err), 0);
    chk("rst_halt",      32'(halt), 1);
    chk("rst_busy",      32'(busy), 0);
    rst = 1'b0;
    mon_off = 0;

    // same-clock ROM, cen every clk, first access forces a table read
    lat_fix = 0;
    repeat (40) step();
    // fixed 5-clk ROM latency
    lat_fix = 5;
    repeat (40) step();
    // cen every 4th clk, random latency
    lat_fix = -1; cen_mode = 1;
    repeat (100) step();
    // random cen with download episodes
    cen_mode = 2;
    for (int ep = 0; ep < 24; ep++) begin
      repeat ($urandom_range(5, 20)) step();
      if (ep % 2 == 0) begin
        n = 0;
        while (!ext_cs && n < 50) begin step(); n++; end
      end
      dl_en = 1'b1;
      n = 0;
      while (!busy && n < 300) begin step(); n++; end
      chk("dl_park", 32'(busy), 1);
      repeat ($urandom_range(2, 8)) step();
      dl_en = 1'b0;
      step();
      chk("dl_resume_cs", 32'(ext_cs), 1);
    end
    // one access just under the limit, then one far past it
    lat_once = TOUT - 1;
    repeat (290) step();
    chk("err_below", 32'(err), 0);
    lat_once = 300;
    repeat (340) step();
    chk("err_set", 32'(err), 1);
    repeat (60) step();
    chk("err_sticky", 32'(err), 1);
    chk("progress", 32'(n_consumed > 100), 1);

    // asynchronous reset in the middle of an access
    mon_off = 1;
    n = 0;
    while (!ext_cs && n < 100) begin step(); n++; end
    chk("pre_rst_cs", 32'(ext_cs), 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_ext_cs", 32'(ext_cs), 0);
    chk("arst_err",    32'(err), 0);
    chk("arst_halt",   32'(halt), 1);
    chk("arst_busy",   32'(busy), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/jtdsp16_rom_arb.md
Name: jtdsp16_rom_arb

Overview:
Arbiter and sequencer for the single external program-ROM port of the DSP16 core. It shares the port between instruction fetch (address = PC) and table reads (`*pt++` accesses that the core's ROM address unit issues). It produces the core halt signal while an access is outstanding, and parks the port while the host downloads firmware. It sits between the ROM address unit and the SDRAM/BRAM ROM controller.

Parameters:
AW, 16, ROM address width
TOUT, 255, wait-clock limit per access before err is flagged (8-bit counter range)

Ports:
clk  in  1  system clock
rst  in  1  reset; asynchronous, active-high
cen  in  1  core clock enable; the core samples halt and the data outputs only on cen
fetch_addr  in  AW  instruction address (core PC)
tbl_addr  in  AW  table pointer value before post-increment
pt_read  in  1  the instruction being executed requests a table read
dl_en  in  1  host firmware download active; ROM port must be released
ext_cs  out  1  ROM request strobe, held until ext_ok
ext_addr  out  AW  ROM address, stable while ext_cs=1
ext_ok  in  1  ROM data valid for the current request (may arrive in the same clk as ext_cs)
ext_data  in  16  ROM read data
ins_dout  out  16  fetched instruction word
tbl_dout  out  16  last table-read word
tbl_valid  out  1  one-clk pulse when tbl_dout updates
halt  out  1  core must not advance PC / execute
busy  out  1  port parked for download
err  out  1  sticky: an access exceeded TOUT wait clocks

Behaviour:
- FSM states: IDLE, FETCH, TABLE, HOLD. All transitions happen on clk; only the HOLD exit and pt_read sampling are cen-qualified.
- Reset values:
  - state=IDLE; ext_cs=0; ext_addr=0; ins_dout=0; tbl_dout=0; tbl_valid=0; err=0.
  - Internal tbl_pend=0 and wait counter=0.
  - halt=1 and busy=0.
- halt = 1 in every state except HOLD; it is combinational from state.
- IDLE:
  - If dl_en=1: stay in IDLE with ext_cs=0, busy=1.
  - Else if tbl_pend=1: go to TABLE with ext_addr<=tbl_latch, ext_cs<=1.
  - Else: go to FETCH with ext_addr<=fetch_addr, ext_cs<=1.
- FETCH: on ext_cs&&ext_ok, ins_dout<=ext_data, ext_cs<=0, go to HOLD.
- TABLE: on ext_cs&&ext_ok:
  - tbl_dout<=ext_data, tbl_valid<=1 for one clk, tbl_pend<=0, ext_cs<=0.
  - Go to IDLE, which issues the next fetch.
- HOLD (halt=0): on the first clk with cen=1:
  - The core consumes ins_dout and advances.
  - If pt_read=1, set tbl_pend<=1 and tbl_latch<=tbl_addr.
  - Go to IDLE.
- Minimum cost per access: fetch takes 3 clk (IDLE, FETCH with same-clk ext_ok, HOLD) plus the wait for cen. A table read adds 2 clk, during which the core stays halted, so tbl_dout is valid before the core next samples.
- Wait counter:
  - Increments each clk in FETCH/TABLE while ext_ok=0; saturates at TOUT.
  - Reaching TOUT sets err=1 (sticky until rst). The access keeps waiting; it is not aborted.
  - The counter clears on every state entry.
- dl_en asserted mid-access (FETCH/TABLE): the access completes normally, then the FSM parks in IDLE.
- dl_en asserted during HOLD: the HOLD cen handshake completes first, then the FSM parks. fetch_addr is unchanged because halt was 1.
- On dl_en fall: the next clk issues a fetch of the current fetch_addr. A pending table read is issued first.
- ext_ok while ext_cs=0 is ignored.
- pt_read outside HOLD, or in HOLD without cen, is ignored.
- rst mid-access drops ext_cs immediately (async). The ROM side must tolerate the abandoned request.
- Address width: ext_addr is exactly AW bits, no arithmetic; tbl_addr is zero-extended by the producer.

Test Plan:
- Reset release, cen=1 every clk, ext_ok returned same clk, fetch_addr=0x0000, ROM[0]=0x1234 -> ext_cs high 1 clk with ext_addr=0; ins_dout=0x1234; halt low exactly 1 clk.
- pt_read=1 in HOLD, tbl_addr=0x0400, ROM[0x400]=0xBEEF, fetch_addr then 0x0001 -> next ext_addr=0x0400; tbl_dout=0xBEEF with 1-clk tbl_valid; then ext_addr=0x0001; halt stays 1 throughout the table read.
- ext_ok delayed 5 clk -> ext_cs and ext_addr stable for 6 clk; halt=1; err=0.
- ext_ok withheld 300 clk with TOUT=255 -> err=1 after 255 wait clocks; access completes when ext_ok arrives; err stays 1 until rst.
- dl_en raised during FETCH -> fetch completes and HOLD handshake executes; then ext_cs=0, busy=1, halt=1; on dl_en low, the fetch of the held fetch_addr is issued next clk.
- cen=1 every 4th clk -> HOLD persists until the cen clk; pt_read asserted on a non-cen clk is ignored (no TABLE access).
